// File: rtl/lzc_pkg.sv
// Shared constants and helpers for the leading-zero counter.
package lzc_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // Bits needed to represent every count from 0 up to and including width.
    function automatic int clog2_plus1(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/lzc_core.sv
// Combinational binary-tree leading-zero encoder.
// The word is zero-padded at the LSB end to a power of two; each tree node
// reports {valid, count} for its slice and the root is saturated to WIDTH.
module lzc_core
    import lzc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = clog2_plus1(WIDTH)
) (
    input  logic [WIDTH-1:0] data_in,
    output logic [CNT_W-1:0] lz_count,
    output logic             all_zero
);

    localparam int LOGP = $clog2(WIDTH);
    localparam int P    = 1 << LOGP;

    // Heap-numbered tree: node 1 is the root, node n has upper child 2n and
    // lower child 2n+1, leaves P..2P-1 hold bits from MSB (P) down to LSB.
    logic [P-1:0]    padded;
    logic            v [1:2*P-1];
    logic [LOGP-1:0] c [1:2*P-1];

    assign padded = P'(data_in) << (P - WIDTH);

    // A leaf is valid when its bit is set; it then has zero leading zeros.
    for (genvar k = 0; k < P; k++) begin : g_leaf
        assign v[P+k] = padded[P-1-k];
        assign c[P+k] = '0;
    end

    // Prefer the upper half; otherwise skip it and count into the lower half.
    for (genvar d = 0; d < LOGP; d++) begin : g_level
        for (genvar i = 0; i < (1 << d); i++) begin : g_node
            localparam int N    = (1 << d) + i;
            localparam int HALF = P >> (d + 1);
            assign v[N] = v[2*N] | v[2*N+1];
            assign c[N] = v[2*N] ? c[2*N] : (c[2*N+1] + LOGP'(HALF));
        end
    end

    // Padding bits are zero, so only an all-zero word leaves the root invalid.
    always_comb begin
        all_zero = ~v[1];
        lz_count = v[1] ? CNT_W'(c[1]) : CNT_W'(WIDTH);
    end

endmodule

// File: rtl/lead_zero_count.sv
// Registered leading-zero counter: one-cycle latency, valid-qualified result.
module lead_zero_count
    import lzc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = clog2_plus1(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    output logic [CNT_W-1:0] lz_count,
    output logic             all_zero
);

    logic [CNT_W-1:0] core_lz;
    logic             core_az;

    logic             out_valid_d, out_valid_q;
    logic [CNT_W-1:0] lz_count_d,  lz_count_q;
    logic             all_zero_d,  all_zero_q;

    lzc_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .data_in  (data_in),
        .lz_count (core_lz),
        .all_zero (core_az)
    );

    // Capture a new result only on accepted words; otherwise hold the last one.
    always_comb begin
        out_valid_d = in_valid;
        lz_count_d  = lz_count_q;
        all_zero_d  = all_zero_q;
        if (in_valid) begin
            lz_count_d = core_lz;
            all_zero_d = core_az;
        end
    end

    // Output registers; reset clears everything, discarding any in-flight word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            lz_count_q  <= '0;
            all_zero_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            lz_count_q  <= lz_count_d;
            all_zero_q  <= all_zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign lz_count  = lz_count_q;
    assign all_zero  = all_zero_q;

endmodule

// File: tb/tb_lead_zero_count.sv
// Bench for lead_zero_count at WIDTH=4, 8 and 5 with a per-DUT scoreboard.
module tb_lead_zero_count;

    typedef struct {
        int lz;
        bit az;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        int         lz;
        bit         az;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       iv4 = 1'b0, iv8 = 1'b0, iv5 = 1'b0;
    logic [3:0] d4 = '0;
    logic [7:0] d8 = '0;
    logic [4:0] d5 = '0;
    logic       ov4, ov8, ov5;
    logic [2:0] lz4;
    logic [3:0] lz8;
    logic [2:0] lz5;
    logic       az4, az8, az5;

    exp_t q4[$], q8[$], q5[$];
    exp_t h4, h8, h5;

    int n_vec = 0;
    int n_fail = 0;

    int exp4 [16] = '{4, 3, 2, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};

    always #5 clk = ~clk;

    lead_zero_count #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .data_in(d4),
        .out_valid(ov4), .lz_count(lz4), .all_zero(az4)
    );
    lead_zero_count #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .data_in(d8),
        .out_valid(ov8), .lz_count(lz8), .all_zero(az8)
    );
    lead_zero_count #(.WIDTH(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv5), .data_in(d5),
        .out_valid(ov5), .lz_count(lz5), .all_zero(az5)
    );

    function automatic int ref_lz(input logic [63:0] d, input int w);
        for (int i = w - 1; i >= 0; i--) begin
            if (d[i]) return w - 1 - i;
        end
        return w;
    endfunction

    task automatic check_out(input string nm, input logic ov, input int lz,
                             input logic az, input bit exp_v, input exp_t e);
        n_vec++;
        if (ov !== exp_v || lz != e.lz || az !== e.az) begin
            n_fail++;
            $display("FAIL %s: got valid=%0b lz=%0d az=%0b, want valid=%0b lz=%0d az=%0b",
                     nm, ov, lz, az, exp_v, e.lz, e.az);
        end
    endtask

    task automatic check_all(input string tag);
        bit have;
        have = (q4.size() > 0);
        if (have) h4 = q4.pop_front();
        check_out({tag, "/w4"}, ov4, int'(lz4), az4, have, h4);
        have = (q8.size() > 0);
        if (have) h8 = q8.pop_front();
        check_out({tag, "/w8"}, ov8, int'(lz8), az8, have, h8);
        have = (q5.size() > 0);
        if (have) h5 = q5.pop_front();
        check_out({tag, "/w5"}, ov5, int'(lz5), az5, have, h5);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        check_all(tag);
        iv4 = 1'b0;
        iv8 = 1'b0;
        iv5 = 1'b0;
    endtask

    task automatic drive4(input logic v, input logic [3:0] d, input int lz, input bit az);
        iv4 = v;
        d4  = d;
        if (v) q4.push_back('{lz, az});
    endtask

    task automatic drive8(input logic [7:0] d, input int lz, input bit az);
        iv8 = 1'b1;
        d8  = d;
        q8.push_back('{lz, az});
    endtask

    task automatic drive5(input logic [4:0] d, input int lz, input bit az);
        iv5 = 1'b1;
        d5  = d;
        q5.push_back('{lz, az});
    endtask

    task automatic clear_model();
        q4.delete();
        q8.delete();
        q5.delete();
        h4 = '{0, 1'b0};
        h8 = '{0, 1'b0};
        h5 = '{0, 1'b0};
    endtask

    vec_t tab4 [16];
    vec_t tab8 [4];
    vec_t tab5 [3];

    initial begin
        for (int i = 0; i < 16; i++) tab4[i] = '{8'(i), exp4[i], (i == 0)};
        tab8[0] = '{8'b0000_0000, 8, 1'b1};
        tab8[1] = '{8'b0000_0001, 7, 1'b0};
        tab8[2] = '{8'b0001_0000, 3, 1'b0};
        tab8[3] = '{8'b1000_0000, 0, 1'b0};
        tab5[0] = '{8'b0000_0000, 5, 1'b1};
        tab5[1] = '{8'b0000_0001, 4, 1'b0};
        tab5[2] = '{8'b0001_0000, 0, 1'b0};

        // Reset state before any clock edge.
        clear_model();
        #3;
        check_all("reset0");
        #9;
        rst_n = 1'b1;

        // Back-to-back sweep of every 4-bit word.
        for (int i = 0; i < 16; i++) begin
            drive4(1'b1, tab4[i].data[3:0], tab4[i].lz, tab4[i].az);
            tick($sformatf("sweep%0d", i));
        end
        tick("sweep_end");

        // Hold: result stays while in_valid is low, even with new data present.
        drive4(1'b1, 4'b0010, 2, 1'b0);
        tick("hold_acc");
        for (int i = 0; i < 3; i++) begin
            drive4(1'b0, 4'b1000, 0, 1'b0);
            tick($sformatf("hold%0d", i));
        end

        // Latency: a single pulse yields exactly one valid cycle.
        drive4(1'b1, 4'b0100, 1, 1'b0);
        tick("lat_acc");
        tick("lat_after1");
        tick("lat_after2");

        // Async reset mid-cycle with a word in flight.
        drive4(1'b1, 4'b0001, 3, 1'b0);
        tick("ar_acc");
        drive4(1'b0, 4'b1000, 0, 1'b0);
        iv4 = 1'b1;
        #2;
        rst_n = 1'b0;
        clear_model();
        #1;
        check_all("ar_immediate");
        tick("ar_held_low");
        #3;
        rst_n = 1'b1;
        iv4 = 1'b0;
        drive4(1'b1, 4'b0001, 3, 1'b0);
        tick("ar_first");
        tick("ar_idle");

        // WIDTH=8 corner words.
        for (int i = 0; i < 4; i++) begin
            drive8(tab8[i].data, tab8[i].lz, tab8[i].az);
            tick($sformatf("w8_%0d", i));
        end

        // WIDTH=5 corner words, then every input against the reference.
        for (int i = 0; i < 3; i++) begin
            drive5(tab5[i].data[4:0], tab5[i].lz, tab5[i].az);
            tick($sformatf("w5_%0d", i));
        end
        for (int i = 0; i < 32; i++) begin
            drive5(5'(i), ref_lz(64'(i), 5), (i == 0));
            tick($sformatf("w5_ref%0d", i));
        end
        tick("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/lead_zero_count.md
Name: lead_zero_count

Overview:
- Registered leading-zero counter.
- Takes a WIDTH-bit word (default 4) and reports how many consecutive zeros precede the most-significant 1, counting from the MSB down.
- Sits in the datapath ahead of normalisation/shift logic.
- One-cycle pipelined result, qualified by a valid strobe.

Parameters:
- WIDTH, 4, input word width; legal values 2..64.
- CNT_W, $clog2(WIDTH+1) (3 for WIDTH=4), width of the count output; must hold the value WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  data_in is sampled this cycle.
- data_in  input  WIDTH  word to be counted; bit WIDTH-1 is the MSB.
- out_valid  output  1  lz_count/all_zero are valid; a single-cycle pulse per accepted input.
- lz_count  output  CNT_W  number of leading zeros of the last accepted word.
- all_zero  output  1  last accepted word was all zeros.

Behaviour:
- Reset (rst_n=0, asynchronous, no clock required): out_valid=0, lz_count=0, all_zero=0. Registers stay cleared while rst_n is low.
- Release of reset is synchronised by the user; the first capture happens on the first rising edge with rst_n=1.
- Count function: lz_count = WIDTH-1-p, where p is the index of the highest set bit of data_in. If data_in==0, lz_count=WIDTH and all_zero=1; otherwise all_zero=0.
- WIDTH=4 mapping:
  - 0000 -> 4
  - 0001 -> 3
  - 001x -> 2
  - 01xx -> 1
  - 1xxx -> 0
- Latency: exactly 1 cycle. On a rising edge with in_valid=1, the count of data_in is registered. out_valid=1 during the following cycle.
- in_valid=0 on an edge: out_valid goes 0; lz_count and all_zero hold their previous values.
- Back-to-back in_valid=1: one result per cycle, no bubbles, no backpressure.
- Reset asserted mid-stream: the in-flight result is discarded and outputs clear immediately.
- data_in with X/Z bits: output is undefined. The bench must not drive it.
- No combinational path from inputs to outputs. All outputs come straight from flops.

Decomposition:
- Package lzc_pkg:
  - function clog2_plus1(width), used to derive CNT_W;
  - localparam DEFAULT_WIDTH=4.
- Sub-module lzc_core (purely combinational, parameter WIDTH): a binary-tree leading-zero encoder.
  - Splits the word into halves recursively; each node emits {valid, count}.
  - If the upper half is nonzero, use its count; else use the lower half's count plus the upper-half width.
  - Supports non-power-of-two WIDTH by zero-padding at the LSB end and saturating the result to WIDTH.
- The top level holds only the input qualification and the output registers.

Test Plan:
- Sweep, WIDTH=4: in_valid=1, data_in=0..15 one per cycle. Each following cycle, lz_count must read 4,3,2,2,1,1,1,1,0,0,0,0,0,0,0,0; all_zero=1 only for input 0; out_valid=1 throughout.
- Hold: accept data_in=0010 (lz=2), then in_valid=0 for 3 cycles with data_in=1000. out_valid=0 and lz_count must stay 2.
- Async reset: accept data_in=0001 (lz=3), assert rst_n low mid-cycle. lz_count=0, out_valid=0 and all_zero=0 immediately, before any clock edge; the first accept after release gives a correct result.
- Latency: single in_valid pulse with data_in=0100. out_valid is high for exactly one cycle, one cycle after the accept, with lz_count=1.
- Parameter, WIDTH=8:
  - 00000000 -> 8, all_zero=1
  - 00000001 -> 7
  - 00010000 -> 3
  - 10000000 -> 0
- Parameter, WIDTH=5 (non-power-of-two):
  - 00000 -> 5
  - 00001 -> 4
  - 10000 -> 0
  - Compare against a behavioural reference over all 32 inputs.
